// File: rtl/pcileech_rst_led_ctl.sv
// pcileech_rst_led_ctl
// Reset and status sequencer that sits in front of the FT601 com, FIFO and
// PCIe blocks. It generates the shared system reset, the FT601 reset and a
// debounced PCIe-core reset, drives the two user LEDs with pulse-stretched
// activity, produces the power-on blink and exports a free-running tick count.
//
// Ports:
//   clk            system clock (single clock domain)
//   rst_n          asynchronous active-low reset
//   pcie_perst_n   PERST# pin, asynchronous to clk
//   pcie_present   board presence pin, asynchronous to clk
//   act_pcie       PCIe activity strobe (1-cycle pulses)
//   act_com        COM activity strobe (1-cycle pulses)
//   tickcount64    free-running 64-bit cycle counter
//   rst            active-high system reset for com/fifo/pcie
//   ft601_rst_n    FT601 reset, always ~rst
//   pcie_rst       active-high PCIe-core reset
//   led_pwronblink power-on blink (feeds the com LED invert input)
//   led_pcie       LD1 drive
//   led_com        LD2 drive
module pcileech_rst_led_ctl #(
  parameter int PARAM_RST_CYCLES     = 64,
  parameter int PARAM_PERST_DEBOUNCE = 1024,
  parameter int PARAM_LED_STRETCH    = 4194304,
  parameter int PARAM_BLINK_BIT      = 24,
  parameter int PARAM_BLINK_END_BIT  = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pcie_perst_n,
  input  logic        pcie_present,
  input  logic        act_pcie,
  input  logic        act_com,
  output logic [63:0] tickcount64,
  output logic        rst,
  output logic        ft601_rst_n,
  output logic        pcie_rst,
  output logic        led_pwronblink,
  output logic        led_pcie,
  output logic        led_com
);

  // One state counter serves both the POR hold and the PERST# debounce.
  localparam int CNT_MAX = (PARAM_RST_CYCLES > PARAM_PERST_DEBOUNCE) ?
                           PARAM_RST_CYCLES : PARAM_PERST_DEBOUNCE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int LED_W   = $clog2(PARAM_LED_STRETCH + 1);

  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(PARAM_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(PARAM_PERST_DEBOUNCE - 1);
  localparam logic [LED_W-1:0] LED_LOAD = LED_W'(PARAM_LED_STRETCH);

  localparam logic [1:0] S_POR  = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RUN  = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic             perst_meta;
  logic             perst_s;
  logic             pres_meta;
  logic             pres_s;
  logic             ok_s;
  logic [LED_W-1:0] led_cnt_pcie;
  logic [LED_W-1:0] led_cnt_com;
  logic             stretch_pcie;
  logic             stretch_com;

  // Free-running tick counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tickcount64 <= '0;
    end else begin
      tickcount64 <= tickcount64 + 64'd1;
    end
  end

  // Two-flop synchronizers for the asynchronous board pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perst_meta <= 1'b0;
      perst_s    <= 1'b0;
      pres_meta  <= 1'b0;
      pres_s     <= 1'b0;
    end else begin
      perst_meta <= pcie_perst_n;
      perst_s    <= perst_meta;
      pres_meta  <= pcie_present;
      pres_s     <= pres_meta;
    end
  end

  assign ok_s = perst_s & pres_s;

  // Reset sequencer. rst and pcie_rst are registered together with the
  // state transition so they change on the same edge as the state does.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_POR;
      cnt      <= '0;
      rst      <= 1'b1;
      pcie_rst <= 1'b1;
    end else begin
      case (state)
        S_POR: begin
          if (cnt == RST_LAST) begin
            state <= S_WAIT;
            cnt   <= '0;
            rst   <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_WAIT: begin
          // A drop on the completing cycle wins: the clear takes priority.
          if (!ok_s) begin
            cnt <= '0;
          end else if (cnt == DEB_LAST) begin
            state    <= S_RUN;
            cnt      <= '0;
            pcie_rst <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RUN: begin
          // Assertion is immediate; only deassertion is debounced.
          if (!ok_s) begin
            state    <= S_WAIT;
            cnt      <= '0;
            pcie_rst <= 1'b1;
          end
        end
        default: begin
          state    <= S_POR;
          cnt      <= '0;
          rst      <= 1'b1;
          pcie_rst <= 1'b1;
        end
      endcase
    end
  end

  assign ft601_rst_n = ~rst;

  // Activity stretchers: a strobe (re)loads the full hold time, giving
  // retrigger and gap-free reload at zero for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_cnt_pcie <= '0;
    end else if (rst) begin
      led_cnt_pcie <= '0;
    end else if (act_pcie) begin
      led_cnt_pcie <= LED_LOAD;
    end else if (led_cnt_pcie != '0) begin
      led_cnt_pcie <= led_cnt_pcie - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_cnt_com <= '0;
    end else if (rst) begin
      led_cnt_com <= '0;
    end else if (act_com) begin
      led_cnt_com <= LED_LOAD;
    end else if (led_cnt_com != '0) begin
      led_cnt_com <= led_cnt_com - 1'b1;
    end
  end

  assign stretch_pcie = (led_cnt_pcie != '0);
  assign stretch_com  = (led_cnt_com != '0);

  // Blink runs only during the first 2^PARAM_BLINK_END_BIT ticks.
  assign led_pwronblink = tickcount64[PARAM_BLINK_BIT] &
                          (tickcount64[63:PARAM_BLINK_END_BIT] == '0);

  // Registered LED drives
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_pcie <= 1'b0;
      led_com  <= 1'b0;
    end else begin
      led_pcie <= (state == S_RUN) ^ stretch_pcie;
      led_com  <= stretch_com ^ led_pwronblink;
    end
  end

endmodule

// File: tb/tb_pcileech_rst_led_ctl.sv
module tb_pcileech_rst_led_ctl;

  localparam int R  = 8;
  localparam int D  = 16;
  localparam int L  = 4;
  localparam int BB = 2;
  localparam int BE = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pcie_perst_n = 1'b1;
  logic        pcie_present = 1'b1;
  logic        act_pcie = 1'b0;
  logic        act_com = 1'b0;
  logic [63:0] tickcount64;
  logic        rst;
  logic        ft601_rst_n;
  logic        pcie_rst;
  logic        led_pwronblink;
  logic        led_pcie;
  logic        led_com;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pcileech_rst_led_ctl #(
    .PARAM_RST_CYCLES    (R),
    .PARAM_PERST_DEBOUNCE(D),
    .PARAM_LED_STRETCH   (L),
    .PARAM_BLINK_BIT     (BB),
    .PARAM_BLINK_END_BIT (BE)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pcie_perst_n  (pcie_perst_n),
    .pcie_present  (pcie_present),
    .act_pcie      (act_pcie),
    .act_com       (act_com),
    .tickcount64   (tickcount64),
    .rst           (rst),
    .ft601_rst_n   (ft601_rst_n),
    .pcie_rst      (pcie_rst),
    .led_pwronblink(led_pwronblink),
    .led_pcie      (led_pcie),
    .led_com       (led_com)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model. Time is the number of clock edges since rst_n release.
  // pcie_rst is low exactly when the synchronized clean condition has held
  // for at least D consecutive edges, counting only edges after the POR hold.
  // A channel's stretch is active for L edges after its last accepted strobe.
  int m_k;
  bit m_h1, m_h2;
  int m_streak;
  bit m_run;
  int m_sp, m_sc;
  bit e_led_pcie, e_led_com;

  function automatic bit blink_at(input longint t);
    return (((t >> BB) & 1) == 1) && ((t >> BE) == 0);
  endfunction

  function automatic bit held(input int t, input int s);
    return (t >= s) && (t - s < L);
  endfunction

  task automatic model_reset();
    m_k = 0; m_h1 = 0; m_h2 = 0; m_streak = 0; m_run = 0;
    m_sp = -100; m_sc = -100; e_led_pcie = 0; e_led_com = 0;
  endtask

  task automatic model_step(input bit pin_ok, input bit ap, input bit ac);
    bit ok_s;
    e_led_pcie = m_run ^ held(m_k, m_sp);
    e_led_com  = held(m_k, m_sc) ^ blink_at(m_k);
    m_k++;
    ok_s = m_h2;
    m_h2 = m_h1;
    m_h1 = pin_ok;
    if (m_k > R) begin
      m_streak = ok_s ? m_streak + 1 : 0;
      if (ap) m_sp = m_k;
      if (ac) m_sc = m_k;
    end
    m_run = (m_k > R) && (m_streak >= D);
  endtask

  task automatic cycle(input bit perst_v, input bit pres_v, input bit ap, input bit ac);
    pcie_perst_n = perst_v;
    pcie_present = pres_v;
    act_pcie     = ap;
    act_com      = ac;
    @(posedge clk);
    model_step(perst_v & pres_v, ap, ac);
    #1;
    check_val("tick", tickcount64, 64'(m_k));
    check_val("rst", rst, m_k < R);
    check_val("ft601_rst_n", ft601_rst_n, !(m_k < R));
    check_val("pcie_rst", pcie_rst, !m_run);
    check_val("led_pwronblink", led_pwronblink, blink_at(m_k));
    check_val("led_pcie", led_pcie, e_led_pcie);
    check_val("led_com", led_com, e_led_com);
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, "_tick"}, tickcount64, 64'd0);
    check_val({tag, "_rst"}, rst, 1'b1);
    check_val({tag, "_ft601_rst_n"}, ft601_rst_n, 1'b0);
    check_val({tag, "_pcie_rst"}, pcie_rst, 1'b1);
    check_val({tag, "_led_pcie"}, led_pcie, 1'b0);
    check_val({tag, "_led_com"}, led_com, 1'b0);
    check_val({tag, "_blink"}, led_pwronblink, 1'b0);
  endtask

  // Asynchronous assertion between edges, then release on a falling edge.
  task automatic async_reset(input string tag);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int rst_fall, pcie_fall, tick_at, e, rise, h, g, t0, first_hi, last_hi, n_hi;
    model_reset();
    #12;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Power-on sequence with clean pins
    rst_fall = -1; pcie_fall = -1; tick_at = -1;
    for (int i = 0; i < 40; i++) begin
      cycle(1, 1, 0, 0);
      if (rst_fall < 0 && rst == 1'b0) begin
        rst_fall = m_k;
        tick_at  = int'(tickcount64);
      end
      if (pcie_fall < 0 && pcie_rst == 1'b0) pcie_fall = m_k;
    end
    check_val("por_rst_edges", rst_fall, R);
    check_val("por_tick_at_rst0", tick_at, R);
    // Pins were already settled through the synchronizers during POR.
    check_val("por_pcie_rst_gap", pcie_fall - rst_fall, D);

    // Runtime PERST# assertion and recovery
    rise = -1;
    cycle(0, 1, 0, 0);
    e = m_k;
    if (pcie_rst == 1'b1) rise = m_k;
    for (int i = 0; i < 5; i++) begin
      cycle(0, 1, 0, 0);
      if (rise < 0 && pcie_rst == 1'b1) rise = m_k;
    end
    check_val("perst_assert_latency", rise - e, 2);
    check_val("perst_rst_stays_low", rst, 1'b0);
    check_val("perst_led_pcie_low", led_pcie, 1'b0);
    h = m_k + 1;
    pcie_fall = -1;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 1, 0, 0);
      if (pcie_fall < 0 && pcie_rst == 1'b0) pcie_fall = m_k;
    end
    check_val("perst_recover_latency", pcie_fall - h, 17);

    // One-cycle PERST# glitch at debounce count 10
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0);
    for (int i = 0; i < 60; i++) begin
      if (m_streak >= 10) break;
      cycle(1, 1, 0, 0);
    end
    check_val("glitch_count_reached", m_streak, 10);
    cycle(0, 1, 0, 0);
    g = m_k;
    pcie_fall = -1;
    for (int i = 0; i < 30; i++) begin
      cycle(1, 1, 0, 0);
      if (pcie_fall < 0 && pcie_rst == 1'b0) pcie_fall = m_k;
    end
    check_val("glitch_recover_latency", pcie_fall - g, 18);

    // COM stretch with retrigger, blink already over
    cycle(1, 1, 0, 1);
    t0 = m_k;
    first_hi = -1; last_hi = -1; n_hi = 0;
    for (int i = 1; i <= 12; i++) begin
      cycle(1, 1, 0, (i == 3));
      if (led_com == 1'b1) begin
        if (first_hi < 0) first_hi = m_k - t0;
        last_hi = m_k - t0;
        n_hi++;
      end
    end
    check_val("stretch_first_hi", first_hi, 1);
    check_val("stretch_last_hi", last_hi, 7);
    check_val("stretch_hi_count", n_hi, 7);

    // Asynchronous reset mid-run with both stretchers loaded
    cycle(1, 1, 1, 1);
    async_reset("midrun");

    // Randomized pins and strobes, including the repeated POR
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 700; i++) begin
        cycle(($urandom_range(0, 29) != 0), ($urandom_range(0, 99) != 0),
              ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
      end
      async_reset("random");
    end
    for (int i = 0; i < 30; i++) cycle(1, 1, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
